// File: rtl/logic_op_arbiter.sv
// Round-robin share of one AND/OR/XOR/NAND unit between two requesters; result registered, 1-cycle latency.
// Backpressure: rsp_ready low while a result is held stalls both requesters; a slot freed by consumption is refilled the same cycle.
module logic_op_arbiter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_slot_free;
  logic             w_gnt_vld;
  logic             w_gnt_id;
  logic             w_accept;
  logic             w_deliver;
  logic [1:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] w_result;

  assign w_slot_free = (r_state == EMPTY) || rsp_ready;
  assign w_deliver   = (r_state == FULL) && rsp_ready;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    w_gnt_vld = 1'b1;
    w_gnt_id  = 1'b0;
    if (req0_valid && req1_valid) w_gnt_id = ~r_last_grant;
    else if (req1_valid)          w_gnt_id = 1'b1;
    else if (!req0_valid)         w_gnt_vld = 1'b0;
  end

  assign req0_ready = w_slot_free && w_gnt_vld && !w_gnt_id && req0_valid;
  assign req1_ready = w_slot_free && w_gnt_vld &&  w_gnt_id && req1_valid;
  assign w_accept   = req0_ready || req1_ready;

  assign w_sel_op = w_gnt_id ? req1_op : req0_op;
  assign w_sel_a  = w_gnt_id ? req1_a  : req0_a;
  assign w_sel_b  = w_gnt_id ? req1_b  : req0_b;

  always_comb begin
    w_result = '0;
    case (w_sel_op)
      2'b00:   w_result = w_sel_a & w_sel_b;
      2'b01:   w_result = w_sel_a | w_sel_b;
      2'b10:   w_result = w_sel_a ^ w_sel_b;
      default: w_result = ~(w_sel_a & w_sel_b);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= EMPTY;
      r_last_grant <= 1'b1;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      if (w_accept) begin
        r_state      <= FULL;
        r_rsp_data   <= w_result;
        r_rsp_id     <= w_gnt_id;
        r_last_grant <= w_gnt_id;
      end else if (w_deliver) begin
        r_state <= EMPTY;
      end
      // Counting uses the id of the result leaving, independent of any new accept.
      if (w_deliver && !r_rsp_id && (r_cnt0 != {CNT_W{1'b1}})) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_deliver &&  r_rsp_id && (r_cnt1 != {CNT_W{1'b1}})) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign rsp_valid = (r_state == FULL);
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign done_cnt0 = r_cnt0;
  assign done_cnt1 = r_cnt1;

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one registered 16-bit logic-operation unit (AND/OR/XOR/NAND) between two requesters.
- Round-robin arbitration on request ports using a valid/ready handshake.
- Registered result on a single response port with a requester ID and backpressure.
- Per-requester saturating completion counters for debug/status.
- Sits between two client FSMs and the shared logic datapath in the in-class exercise design.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CNT_W, 8, width of each completion counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle when high together with req0_valid.
- req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NAND.
- req0_a  input  WIDTH  requester 0 operand a.
- req0_b  input  WIDTH  requester 0 operand b.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as above, for requester 1.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_id  output  1  requester that issued the held result.
- rsp_data  output  WIDTH  held result.
- done_cnt0  output  CNT_W  responses delivered to requester 0; saturates at all-ones.
- done_cnt1  output  CNT_W  responses delivered to requester 1; saturates at all-ones.

Behaviour:
- Reset values (the cycle after reset is sampled high):
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - done_cnt0 = done_cnt1 = 0.
  - Reset overrides every other input.
  - A response pending at reset is discarded and never counted.
- FSM, two states:
  - EMPTY (rsp_valid = 0).
  - FULL (rsp_valid = 1).
- Slot free: slot_free = EMPTY, or (FULL and rsp_ready).
- Grant (combinational):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the ID not equal to last_grant.
  - Neither valid: no grant.
- Ready outputs:
  - reqN_ready = slot_free and (grant == N) and reqN_valid.
  - At most one ready high per cycle.
  - Ready never depends on opcode or operand values.
- Accept (reqN_valid and reqN_ready at a clock edge):
  - rsp_data <= op(reqN_a, reqN_b).
  - rsp_id <= N.
  - rsp_valid <= 1.
  - last_grant <= N.
- Op table: 00 a&b; 01 a|b; 10 a^b; 11 ~(a&b). Full WIDTH bits; no truncation.
- Latency: result visible on rsp_* one cycle after acceptance.
- Throughput:
  - One operation per cycle when rsp_ready is held high.
  - Accepting a new request in the same cycle the held response is consumed is required (FULL stays FULL, new data loaded).
- Response handshake:
  - While FULL and rsp_ready = 0: rsp_valid, rsp_id and rsp_data hold stable; both reqN_ready = 0.
  - FULL, rsp_ready = 1, no accept: go to EMPTY. rsp_data and rsp_id keep their last value; don't-care while rsp_valid = 0.
- Counters:
  - On rsp_valid and rsp_ready, increment done_cnt[rsp_id] by 1 unless it is already all-ones.
  - Counter increment and a new accept in the same cycle are independent and both take effect.
- Requester rule: payload stays stable while valid is high and ready is low. The arbiter does not latch unaccepted requests.
- Fairness: with both requesters continuously valid and rsp_ready = 1, grants alternate 0,1,0,1,...

Test Plan:
- Reset, then req0 only (op=00, a=16'hF0F0, b=16'hFF00), rsp_ready=1 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=16'hF000; done_cnt0=1 one cycle later.
- All four ops on req1 with a=16'h1234, b=16'h0FF0 back-to-back, rsp_ready=1 -> rsp_data sequence 0230, 1FF4, 1DC4, FDCF; rsp_id=1; one result per cycle.
- Both valid continuously for 6 cycles from reset, rsp_ready=1 -> grant order 0,1,0,1,0,1; done_cnt0=3, done_cnt1=3.
- rsp_ready=0 for 4 cycles while FULL with both valid -> rsp_* stable, both ready=0; on rsp_ready=1, new accept the same cycle, held result counted once.
- Assert reset while FULL with rsp_ready=0 -> next cycle rsp_valid=0, counters 0, held result never counted; first tie afterwards goes to requester 0.
- Preload done_cnt1 to 8'hFE via 254 req1 ops, then 3 more -> done_cnt1 reaches 8'hFF and stays; done_cnt0 unchanged.
